// File: rtl/conv_seq_ctrl.sv
// Strobe sequencer for the convolver array: clears line buffers, loads filter taps,
// streams pixels and flags complete 3x3 windows (IDLE, CLEAR, LOAD_F, STREAM, DRAIN, DONE).
module conv_seq_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int N_TAPS  = 9,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_length,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              line_buffer_reset,
  output logic              shifting_filter,
  output logic              shifting_line,
  output logic              mac_enable,
  output logic              output_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_F,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  len_q;
  logic [ADDR_W-1:0]  rows_q;
  logic [ADDR_W-1:0]  col;
  logic [ADDR_W-1:0]  row;
  logic [TAP_W-1:0]   taps_left;
  logic [MAC_LAT-1:0] dline;
  logic [MAC_LAT-1:0] dline_next;
  logic               xfer;
  logic               window;
  logic               last_col;
  logic               last_px;

  assign in_ready          = (state == LOAD_F) || (state == STREAM);
  assign xfer              = in_valid && in_ready;
  assign shifting_filter   = in_valid && (state == LOAD_F);
  assign shifting_line     = in_valid && (state == STREAM);
  assign line_buffer_reset = (state == CLEAR);
  assign busy              = (state != IDLE);
  assign done              = (state == DONE);

  assign window   = (row >= ADDR_W'(2)) && (col >= ADDR_W'(2));
  assign last_col = (col == len_q - ADDR_W'(1));
  assign last_px  = last_col && (row == rows_q - ADDR_W'(1));

  // Bit k holds mac_enable delayed by k+1 cycles; the top bit is output_valid.
  assign dline_next   = MAC_LAT'({dline, mac_enable});
  assign output_valid = dline[MAC_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= '0;
      rows_q     <= '0;
      col        <= '0;
      row        <= '0;
      taps_left  <= '0;
      mac_enable <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= 1'b0;
      mac_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ((row_length >= ADDR_W'(3)) && (num_rows >= ADDR_W'(3))) begin
              len_q  <= row_length;
              rows_q <= num_rows;
              state  <= CLEAR;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          taps_left <= TAP_W'(N_TAPS - 1);
          col       <= '0;
          row       <= '0;
          state     <= LOAD_F;
        end
        LOAD_F: begin
          if (xfer) begin
            if (taps_left == '0) state <= STREAM;
            else taps_left <= taps_left - TAP_W'(1);
          end
        end
        STREAM: begin
          if (xfer) begin
            mac_enable <= window;
            if (last_px) state <= DRAIN;
            if (last_col) begin
              col <= '0;
              row <= row + ADDR_W'(1);
            end else begin
              col <= col + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (dline_next == '0) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dline <= '0;
    else      dline <= dline_next;
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized-stall bench for conv_seq_ctrl: a transfer-level model schedules every
// expected strobe by cycle number and totals are checked against frame arithmetic.
module tb_conv_seq_ctrl;
  localparam int ADDR_W  = 8;
  localparam int N_TAPS  = 9;
  localparam int MAC_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [ADDR_W-1:0] row_length = '0;
  logic [ADDR_W-1:0] num_rows = '0;
  logic in_ready, line_buffer_reset, shifting_filter, shifting_line;
  logic mac_enable, output_valid, busy, done, err;

  int checks = 0;
  int errors = 0;

  conv_seq_ctrl #(.ADDR_W(ADDR_W), .N_TAPS(N_TAPS), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .row_length(row_length), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .line_buffer_reset(line_buffer_reset),
    .shifting_filter(shifting_filter), .shifting_line(shifting_line),
    .mac_enable(mac_enable), .output_valid(output_valid), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {in_ready, line_buffer_reset, shifting_filter, shifting_line,
            mac_enable, output_valid, busy, done, err};
  endfunction

  // Cycle k=0 carries start; the task returns after checking the done cycle, so the
  // next call begins in the very next cycle (back-to-back start).
  task automatic run_frame(input int len, input int rows, input int stall_pct, input bit poke);
    bit exp_mac[0:4095];
    bit exp_ov[0:4095];
    int taps, pix, total, done_k, k;
    int n_sf, n_sl, n_mac, n_ov, n_lbr;
    bit ev, erdy, poked;
    for (int i = 0; i < 4096; i++) begin
      exp_mac[i] = 1'b0;
      exp_ov[i]  = 1'b0;
    end
    taps = 0; pix = 0; total = len * rows; done_k = -1; k = 0;
    n_sf = 0; n_sl = 0; n_mac = 0; n_ov = 0; n_lbr = 0; poked = 1'b0;
    while (1) begin
      @(negedge clk);
      ev       = ($urandom_range(99) >= stall_pct);
      in_valid = ev;
      start    = (k == 0);
      if (k == 0) begin
        row_length = ADDR_W'(len);
        num_rows   = ADDR_W'(rows);
      end
      if (poke && !poked && taps == N_TAPS && pix == len + 1) begin
        start      = 1'b1;
        row_length = ADDR_W'(200);
        poked      = 1'b1;
      end
      #1;
      erdy = (k >= 2) && (pix < total);
      chk1("in_ready", in_ready, erdy);
      chk1("shifting_filter", shifting_filter, erdy && (taps < N_TAPS) && ev);
      chk1("shifting_line", shifting_line, erdy && (taps == N_TAPS) && ev);
      chk1("line_buffer_reset", line_buffer_reset, k == 1);
      chk1("mac_enable", mac_enable, exp_mac[k]);
      chk1("output_valid", output_valid, exp_ov[k]);
      chk1("busy", busy, k >= 1);
      chk1("done", done, k == done_k);
      chk1("err", err, 1'b0);
      n_sf  += int'(shifting_filter);
      n_sl  += int'(shifting_line);
      n_mac += int'(mac_enable);
      n_ov  += int'(output_valid);
      n_lbr += int'(line_buffer_reset);
      if (erdy && ev) begin
        if (taps < N_TAPS) taps++;
        else begin
          if ((pix / len) >= 2 && (pix % len) >= 2) begin
            exp_mac[k + 1]           = 1'b1;
            exp_ov[k + 1 + MAC_LAT]  = 1'b1;
          end
          pix++;
          if (pix == total) done_k = k + 2 + MAC_LAT;
        end
      end
      if (k == done_k) break;
      if (k >= 3000) begin
        chkn("frame_timeout", k, done_k);
        break;
      end
      k++;
    end
    start = 1'b0;
    chkn("total_line_buffer_reset", n_lbr, 1);
    chkn("total_shifting_filter", n_sf, N_TAPS);
    chkn("total_shifting_line", n_sl, total);
    chkn("total_mac_enable", n_mac, (len - 2) * (rows - 2));
    chkn("total_output_valid", n_ov, (len - 2) * (rows - 2));
  endtask

  task automatic bad_geom(input int len, input int rows);
    @(negedge clk);
    start = 1'b1; row_length = ADDR_W'(len); num_rows = ADDR_W'(rows); in_valid = 1'b1;
    #1;
    chkn("bad_geom_cycle0", int'(outs()), 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk1("bad_geom_err", err, k == 1);
      chkn("bad_geom_others", int'(outs() >> 1), 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    #1;
    chkn("reset_outputs", int'(outs()), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_frame(5, 4, 0, 1'b0);
    run_frame(5, 4, 40, 1'b0);
    run_frame(5, 4, 60, 1'b0);
    run_frame(3, 3, 0, 1'b0);
    run_frame(3, 3, 30, 1'b0);
    bad_geom(2, 8);
    bad_geom(8, 2);
    run_frame(6, 5, 25, 1'b1);
    for (int i = 0; i < 3; i++)
      run_frame(int'($urandom_range(7, 3)), int'($urandom_range(6, 3)),
                int'($urandom_range(50, 0)), 1'b0);

    // Abort a frame while a window is being computed.
    @(negedge clk);
    start = 1'b1; row_length = ADDR_W'(5); num_rows = ADDR_W'(4); in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    #1;
    chk1("pre_abort_busy", busy, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chkn("abort_outputs", int'(outs()), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chkn("post_abort_idle", int'(outs()), 0);
    end
    run_frame(4, 3, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Sequencing controller that sits directly upstream of the convolver array wrapper and generates its control strobes: line-buffer clear, 9-tap filter load, per-pixel line shift, MAC enable and output-valid. It accepts a frame geometry and a valid/ready pixel stream from the feature-map fetch stage. It counts row/column position so that MAC enables and output-valid pulses are issued only for complete 3x3 windows.

## Interface
- ADDR_W, 8, width of row_length / num_rows / position counters (matches line-buffer address width)
- N_TAPS, 9, filter taps shifted in per frame
- MAC_LAT, 2, cycles from mac_enable to convolver result valid (must be ≥1)

- clk  input  1  system clock, all logic rising-edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to process one frame; sampled only in IDLE
- row_length  input  ADDR_W  pixels per row; sampled on accepted start
- num_rows  input  ADDR_W  rows per frame; sampled on accepted start
- in_valid  input  1  upstream has a tap (LOAD_F) or pixel (STREAM) on the data bus
- in_ready  output  1  controller accepts the current word; transfer = in_valid & in_ready
- line_buffer_reset  output  1  clear convolver line buffers
- shifting_filter  output  1  shift one filter tap into convolvers
- shifting_line  output  1  shift one pixel into convolver line buffers
- mac_enable  output  1  compute on current 3x3 window
- output_valid  output  1  convolver output valid this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at frame completion
- err  output  1  one-cycle pulse when start rejected for bad geometry

## Operation
- States: IDLE, CLEAR, LOAD_F, STREAM, DRAIN, DONE.
- IDLE: start=1 with row_length≥3 and num_rows≥3 → latch geometry, go CLEAR. If start=1 and either value is <3, pulse err next cycle and stay IDLE.
- CLEAR: line_buffer_reset=1 for exactly one cycle → LOAD_F.
- LOAD_F: in_ready=1; shifting_filter = in_valid (combinational). Tap counter increments per transfer. After transfer N_TAPS (the 9th) → STREAM.
- STREAM: in_ready=1; shifting_line = in_valid (combinational). col counts 0..row_length-1 and wraps to 0 with row+1. A transfer with row≥2 and col≥2 is a window pixel. The transfer at row=num_rows-1, col=row_length-1 → DRAIN.
- mac_enable: registered. High the cycle after each window-pixel transfer, otherwise 0.
- output_valid: mac_enable delayed by MAC_LAT through a shift register that advances every cycle, independent of stalls.
- DRAIN: in_ready=0. Wait until the output_valid delay line is empty → DONE.
- DONE: done=1 for one cycle → IDLE.
- in_ready=0 in IDLE, CLEAR, DRAIN and DONE. line_buffer_reset, shifting_filter and shifting_line are 0 outside their own states.
- start outside IDLE is ignored (no err).
- Stall (in_valid=0): counters hold and no shift strobe is issued. The pending mac/output_valid pipeline keeps draining.
- Counters are ADDR_W bits wide. Comparisons use the latched geometry, so input changes during a frame have no effect.
- Outputs per frame = (num_rows-2)·(row_length-2).

## Timing
- Reset (rst=0, asynchronous): state=IDLE. All counters and the delay line clear. in_ready, line_buffer_reset, shifting_filter, shifting_line, mac_enable, output_valid, busy, done and err are all 0. Reset mid-frame aborts immediately; nothing resumes after release.
- start accepted at edge t: busy=1 and line_buffer_reset=1 in cycle t+1. in_ready=1 from cycle t+2.
- Filter tap k is transferred in the same cycle as its shifting_filter pulse.
- Window pixel transferred in cycle c: mac_enable=1 in c+1, output_valid=1 in c+1+MAC_LAT.
- Last pixel in cycle L: DRAIN from L+1, done in L+2+MAC_LAT, IDLE and busy=0 in L+3+MAC_LAT.
- Back-to-back: start in the cycle after done is accepted.

## Test plan
- Reset: assert rst=0 mid-STREAM → all outputs 0 within the same cycle. After release, the FSM stays in IDLE until start.
- Nominal: row_length=5, num_rows=4, in_valid always 1 → 1 line_buffer_reset pulse, 9 shifting_filter, 20 shifting_line, 6 mac_enable and 6 output_valid. mac_enable follows pixel indices 12,13,14,17,18,19. done arrives MAC_LAT+2 cycles after pixel 19.
- Stalls: same frame with in_valid toggling in a random pattern → identical pulse counts. Every mac_enable follows a window transfer by 1 cycle. No shift strobe fires while in_valid=0.
- Bad geometry: start with row_length=2, num_rows=8 → err pulse 1 cycle later, busy stays 0, and no strobes fire.
- Minimum frame: row_length=3, num_rows=3 → exactly 1 output_valid, at pixel 8 + 1 + MAC_LAT.
- Ignored start: pulse start during STREAM and raise row_length to 200 → frame completes with the latched geometry and the total output count is unchanged.
